// File: rtl/control_unit_pipe_if.sv
// ID-stage to ID/EXE control bundle: decode inputs, hazard/flush/memory handshakes,
// and the registered control fields driven back out.
interface control_unit_pipe_if #(
  parameter int unsigned CMD_W = 4
);
  logic             valid_in;
  logic [1:0]       mode;
  logic [3:0]       op_code;
  logic             s_in;
  logic [3:0]       cond;
  logic [3:0]       status;
  logic             hazard;
  logic             flush;
  logic             mem_ready;
  logic [CMD_W-1:0] exe_cmd;
  logic             mem_read_en;
  logic             mem_write_en;
  logic             wb_en;
  logic             b;
  logic             s_out;
  logic             valid_out;
  logic             stall_out;
  logic             illegal;
  logic             mem_timeout;

  modport master (
    output valid_in, mode, op_code, s_in, cond, status, hazard, flush, mem_ready,
    input  exe_cmd, mem_read_en, mem_write_en, wb_en, b, s_out, valid_out, stall_out,
           illegal, mem_timeout
  );

  modport slave (
    input  valid_in, mode, op_code, s_in, cond, status, hazard, flush, mem_ready,
    output exe_cmd, mem_read_en, mem_write_en, wb_en, b, s_out, valid_out, stall_out,
           illegal, mem_timeout
  );
endinterface

// File: rtl/control_unit_pipe.sv
// Registered, condition-aware ID-stage control decoder with hazard bubbles, flush and a
// memory-wait FSM that stalls the front end until the data memory acknowledges or times out.
module control_unit_pipe #(
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned MEM_TO = 15,
  parameter int unsigned TO_W   = $clog2(MEM_TO + 1)
) (
  input logic                clk,
  input logic                rst,
  control_unit_pipe_if.slave bus
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  typedef struct packed {
    logic [CMD_W-1:0] exe_cmd;
    logic             mem_read_en;
    logic             mem_write_en;
    logic             wb_en;
    logic             b;
    logic             s_out;
    logic             valid;
  } ctrl_t;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  ctrl_t           ctrl_q, ctrl_d, dec;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;
  logic            dec_illegal;
  logic            cond_pass;
  logic            n, z, c, v;

  assign {n, z, c, v} = bus.status;

  always_comb begin
    cond_pass = 1'b0;
    unique case (bus.cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c & !z;
      4'b1001: cond_pass = !c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec_illegal = 1'b0;
    unique case (bus.mode)
      2'b00: begin
        dec.wb_en = 1'b1;
        dec.s_out = bus.s_in;
        case (bus.op_code)
          4'b1101: dec.exe_cmd = CMD_W'(4'b0001);
          4'b1111: dec.exe_cmd = CMD_W'(4'b1001);
          4'b0100: dec.exe_cmd = CMD_W'(4'b0010);
          4'b0101: dec.exe_cmd = CMD_W'(4'b0011);
          4'b0010: dec.exe_cmd = CMD_W'(4'b0100);
          4'b0110: dec.exe_cmd = CMD_W'(4'b0101);
          4'b0000: dec.exe_cmd = CMD_W'(4'b0110);
          4'b1100: dec.exe_cmd = CMD_W'(4'b0111);
          4'b0001: dec.exe_cmd = CMD_W'(4'b1000);
          // Compares only set flags: no writeback, S forced.
          4'b1010: begin
            dec.exe_cmd = CMD_W'(4'b0100);
            dec.wb_en   = 1'b0;
            dec.s_out   = 1'b1;
          end
          4'b1000: begin
            dec.exe_cmd = CMD_W'(4'b0110);
            dec.wb_en   = 1'b0;
            dec.s_out   = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b01: begin
        dec.exe_cmd = CMD_W'(4'b0010);
        if (bus.s_in) begin
          dec.mem_read_en = 1'b1;
          dec.wb_en       = 1'b1;
        end else begin
          dec.mem_write_en = 1'b1;
        end
      end
      2'b10:   dec.b = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    if (bus.flush) begin
      ctrl_d  = '0;
      state_d = StRun;
      cnt_d   = '0;
    end else if (state_q == StMemWait) begin
      if (bus.mem_ready) begin
        ctrl_d  = '0;
        state_d = StRun;
        cnt_d   = '0;
      end else if (cnt_q == TO_W'(MEM_TO)) begin
        ctrl_d    = '0;
        state_d   = StRun;
        cnt_d     = '0;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end else if (!bus.valid_in || bus.hazard || !cond_pass || dec_illegal) begin
      ctrl_d    = '0;
      illegal_d = bus.valid_in & !bus.hazard & cond_pass & dec_illegal;
    end else begin
      ctrl_d = dec;
      if (dec.mem_read_en || dec.mem_write_en) begin
        state_d = StMemWait;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.exe_cmd      = ctrl_q.exe_cmd;
  assign bus.mem_read_en  = ctrl_q.mem_read_en;
  assign bus.mem_write_en = ctrl_q.mem_write_en;
  assign bus.wb_en        = ctrl_q.wb_en;
  assign bus.b            = ctrl_q.b;
  assign bus.s_out        = ctrl_q.s_out;
  assign bus.valid_out    = ctrl_q.valid;
  assign bus.illegal      = illegal_q;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_out    = !rst & ((state_q == StMemWait) |
                                    (bus.hazard & bus.valid_in & !bus.flush));

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Registered, condition-aware successor to the ID-stage control decoder for the ARM-subset pipeline.
- Decodes mode/opcode/S and evaluates the ARM condition field against the status register (NZCV).
- Drives the ID/EXE control fields with one-cycle latency.
- Adds hazard bubbles, flush, and a memory-wait FSM with timeout that stalls the front end until the data memory acknowledges.

Parameters:
- CMD_W, 4, width of exe_cmd; codes are zero-extended into this width.
- MEM_TO, 15, maximum cycles spent in MEM_WAIT before abort (>=1).
- TO_W, $clog2(MEM_TO+1), width of the wait counter.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  ID stage holds a real instruction
- mode  in  2  instr[27:26]
- op_code  in  4  instr[24:21]
- s_in  in  1  instr[20] (S bit / L bit for memory)
- cond  in  4  instr[31:28]
- status  in  4  {N,Z,C,V} from status register
- hazard  in  1  data hazard detected; insert bubble
- flush  in  1  branch taken in EXE; kill ID instruction
- mem_ready  in  1  data memory completed current access
- exe_cmd  out  CMD_W  ALU command (registered)
- mem_read_en, mem_write_en, wb_en, b, s_out  out  1 each  registered control
- valid_out  out  1  registered control fields are a live instruction
- stall_out  out  1  freeze PC and IF/ID (combinational)
- illegal  out  1  one-cycle pulse: undefined mode/opcode issued
- mem_timeout  out  1  one-cycle pulse: memory op aborted

Behaviour:
- Reset (rst high at edge):
  - all registered outputs 0, illegal 0, mem_timeout 0;
  - FSM to RUN, counter 0.
- Priority each edge: rst > flush > MEM_WAIT handling > hazard > normal issue.
- Condition pass: 0000 EQ Z, 0001 NE !Z, 0010 CS C, 0011 CC !C, 0100 MI N, 0101 PL !N, 0110 VS V, 0111 VC !V, 1000 HI C&!Z, 1001 LS !C|Z, 1010 GE N==V, 1011 LT N!=V, 1100 GT !Z&(N==V), 1101 LE Z|(N!=V), 1110 AL 1, 1111 fail.
- Decode, mode 00 (wb_en=1, s_out=s_in):
  - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011;
  - SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000.
- Decode, mode 00 compares: CMP 1010->0100 and TST 1000->0110; wb_en=0, s_out forced 1.
- Decode, mode 00 other opcodes: illegal.
- Decode, mode 01 (memory):
  - exe_cmd=0010, s_out=0;
  - s_in=1 LDR: mem_read_en=1, wb_en=1;
  - s_in=0 STR: mem_write_en=1, wb_en=0.
- Decode, mode 10: b=1, all other enables 0, exe_cmd 0.
- Decode, mode 11: illegal.
- Issue in RUN, next edge:
  - Bubble (all control fields 0, valid_out 0) when any of these hold: valid_in=0, hazard=1, condition fails, or illegal.
  - Otherwise decoded fields latch and valid_out=1.
  - illegal pulses only when valid_in=1, hazard=0 and the condition passes.
- Memory-wait FSM:
  - RUN -> MEM_WAIT when a memory op issues; counter loads 0.
  - In MEM_WAIT, output register holds the memory op (valid_out=1) and new ID input is ignored.
  - mem_ready=1 in MEM_WAIT -> next edge: output register cleared to bubble, FSM to RUN.
  - mem_ready=0 -> counter increments.
  - When counter==MEM_TO with mem_ready=0 -> next edge: bubble, RUN, mem_timeout pulses 1 cycle.
  - mem_ready and timeout in the same cycle: mem_ready wins, no timeout pulse.
  - mem_ready while in RUN is ignored.
- stall_out = (state==MEM_WAIT) | (hazard & valid_in & !flush). It is 0 during rst.
- flush:
  - next edge forces a bubble, FSM to RUN, counter 0, no illegal/timeout pulse;
  - in MEM_WAIT it aborts the pending op.
- Back-to-back ops: a data-proc op after a completed memory op issues on the edge after RUN is re-entered. The front end held it via stall_out, so nothing is lost.

Test Plan:
- Reset: rst=1 with valid ADD (cond=1110) -> every output 0; release -> next edge exe_cmd=0010, wb_en=1, valid_out=1.
- Condition: status=0100 (Z=1), cond=0001 NE with SUB -> bubble. Same with cond=0000 EQ -> exe_cmd=0100, wb_en=1. CMP with s_in=0 -> s_out=1, wb_en=0.
- LDR with mem_ready low 3 cycles then high:
  - mem_read_en=1, wb_en=1 held 4 cycles;
  - stall_out=1 during wait, then bubble and RUN;
  - STR -> mem_write_en=1, wb_en=0.
- Timeout with MEM_TO=15, mem_ready never asserted: mem_timeout pulses exactly once, 16 cycles after entering MEM_WAIT. Then bubble, stall_out=0.
- Hazard and flush:
  - hazard=1 with ADD -> stall_out=1, bubble. Hazard drops -> ADD issues.
  - flush=1 in MEM_WAIT -> next edge bubble, RUN, no timeout.
- Illegal: mode=11 -> illegal pulses 1 cycle, valid_out=0. Mode 00 op 0011 -> illegal. Mode 10 -> b=1, exe_cmd=0.
